// File: rtl/llr_block_interleaver.sv
// Ping-pong row/column block interleaver for turbo-decoder extrinsic LLRs.
// Natural-order frames are written into one bank while the other is read out permuted.
module llr_block_interleaver #(
    parameter int ROWS = 4,
    parameter int COLS = 8,
    parameter int DW   = 16
) (
    input  logic          clk_p_i,
    input  logic          reset_n_i,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic          mode_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          last_o
);
    localparam int N  = ROWS * COLS;
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    typedef logic [AW-1:0] ptr_t;

    localparam ptr_t LAST = ptr_t'(N - 1);
    localparam ptr_t R_M1 = ptr_t'(ROWS - 1);
    localparam ptr_t C_M1 = ptr_t'(COLS - 1);
    localparam ptr_t R_ST = ptr_t'(ROWS);
    localparam ptr_t C_ST = ptr_t'(COLS);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    logic [DW-1:0] mem [2][N];
    logic [1:0]    full;
    logic [1:0]    bank_mode;
    logic          wr_bank;
    ptr_t          wcnt;

    state_t        state;
    logic          rd_bank;
    ptr_t          rd_inn;
    ptr_t          rd_out;
    ptr_t          rd_addr;
    ptr_t          rd_k;

    logic          accept;
    logic          wr_done;
    logic          consume;
    logic          drop;
    logic          ld;
    logic          ld_bank;
    logic          ld_mode;
    ptr_t          src_inn;
    ptr_t          src_out;
    ptr_t          src_addr;
    ptr_t          src_k;
    ptr_t          nxt_inn;
    ptr_t          nxt_out;
    ptr_t          nxt_addr;
    ptr_t          nxt_k;
    ptr_t          inn_max;
    ptr_t          stride;

    assign ready_o = !full[wr_bank];
    assign accept  = valid_i && ready_o;
    assign wr_done = accept && (wcnt == LAST);
    assign consume = valid_o && ready_i;

    // Frame storage: words land at their natural-order address
    always_ff @(posedge clk_p_i) begin
        if (accept) begin
            mem[wr_bank][wcnt] <= data_i;
        end
    end

    // Write pointer, per-bank mode latch and bank full flags
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wcnt      <= '0;
            wr_bank   <= 1'b0;
            bank_mode <= '0;
            full      <= '0;
        end else begin
            if (accept) begin
                if (wcnt == '0) begin
                    bank_mode[wr_bank] <= mode_i;
                end
                if (wr_done) begin
                    wcnt    <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (drop && (rd_bank == 1'(b))) begin
                    full[b] <= 1'b0;
                end else if (wr_done && (wr_bank == 1'(b))) begin
                    full[b] <= 1'b1;
                end
            end
        end
    end

    // Pick which element (bank and traversal position) loads this cycle
    always_comb begin
        ld       = 1'b0;
        drop     = 1'b0;
        ld_bank  = rd_bank;
        src_inn  = rd_inn;
        src_out  = rd_out;
        src_addr = rd_addr;
        src_k    = rd_k;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    ld       = 1'b1;
                    src_inn  = '0;
                    src_out  = '0;
                    src_addr = '0;
                    src_k    = '0;
                end
            end
            default: begin
                if (consume) begin
                    if (last_o) begin
                        drop     = 1'b1;
                        ld_bank  = !rd_bank;
                        ld       = full[!rd_bank];
                        src_inn  = '0;
                        src_out  = '0;
                        src_addr = '0;
                        src_k    = '0;
                    end else begin
                        ld = 1'b1;
                    end
                end
            end
        endcase
    end

    // Nested-counter address walk: inner steps by a stride, outer restarts a column
    always_comb begin
        ld_mode = bank_mode[ld_bank];
        inn_max = ld_mode ? C_M1 : R_M1;
        stride  = ld_mode ? R_ST : C_ST;
        nxt_k   = src_k + 1'b1;
        if (src_inn == inn_max) begin
            nxt_inn  = '0;
            nxt_out  = src_out + 1'b1;
            nxt_addr = src_out + 1'b1;
        end else begin
            nxt_inn  = src_inn + 1'b1;
            nxt_out  = src_out;
            nxt_addr = src_addr + stride;
        end
    end

    // Read-side state, traversal counters and registered output
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_inn  <= '0;
            rd_out  <= '0;
            rd_addr <= '0;
            rd_k    <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end else begin
            if (drop) begin
                rd_bank <= !rd_bank;
            end
            if (ld) begin
                data_o  <= mem[ld_bank][src_addr];
                valid_o <= 1'b1;
                last_o  <= (src_k == LAST);
                rd_inn  <= nxt_inn;
                rd_out  <= nxt_out;
                rd_addr <= nxt_addr;
                rd_k    <= nxt_k;
                state   <= DRAIN;
            end else if (drop) begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
                state   <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_llr_block_interleaver.sv
// Bench for llr_block_interleaver: scoreboard driven by a permutation model.
// Directed scenarios plus randomized handshakes and mid-frame resets.
module tb_llr_block_interleaver;
    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int DW   = 16;
    localparam int N    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic          mode_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] out_log[$];
    logic [DW-1:0] fr_buf[N];
    logic [DW-1:0] cur[N];
    int            wcount;
    int            fc;
    int            n_chk;
    int            n_fail;
    int            consumed;
    int            nb_seen;
    int            rpol;
    int            lat_cnt;
    bit            fmode;
    bit            nb_pend;
    bit            stall_prev;
    logic [DW-1:0] hold_d;
    logic          hold_l;

    llr_block_interleaver #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk_p_i   (clk),
        .reset_n_i (rst_n),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .mode_i    (mode_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .last_o    (last_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference permutation straight from the row/column formulas
    task automatic push_frame();
        for (int k = 0; k < N; k++) begin
            exp_t e;
            int   a;
            if (fmode) a = (k % COLS) * ROWS + k / COLS;
            else       a = (k % ROWS) * COLS + k / ROWS;
            e.d = cur[a];
            e.l = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: observes both handshakes half a cycle before each edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (lat_cnt == 2) begin
                check("lat_early", valid_o, 0);
                lat_cnt = 1;
            end else if (lat_cnt == 1) begin
                check("lat", valid_o, 1);
                lat_cnt = 0;
            end
            if (nb_pend) begin
                check("no_bubble", valid_o, 1);
                nb_seen++;
                nb_pend = 0;
            end
            check("ready", ready_o, fc < 2);
            if (stall_prev) begin
                check("hold_valid", valid_o, 1);
                check("hold_data", data_o, hold_d);
                check("hold_last", last_o, hold_l);
            end
            stall_prev = valid_o && !ready_i;
            hold_d     = data_o;
            hold_l     = last_o;
            if (valid_o && ready_i) begin
                consumed++;
                out_log.push_back(data_o);
                if (exp_q.size() == 0) begin
                    check("spurious_out", valid_o, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("data", data_o, e.d);
                    check("last", last_o, e.l);
                    if (e.l) begin
                        fc--;
                        if (exp_q.size() > 0) nb_pend = 1;
                    end
                end
            end
            if (valid_i && ready_o) begin
                if (wcount == 0) fmode = mode_i;
                cur[wcount] = data_i;
                wcount++;
                if (wcount == N) begin
                    if (exp_q.size() == 0 && !valid_o) lat_cnt = 2;
                    push_frame();
                    fc++;
                    wcount = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rpol)
            0:       ready_i = 1'b1;
            1:       ready_i = 1'b0;
            default: ready_i = ($urandom_range(99) < 60);
        endcase
    endtask

    task automatic send_words(input bit m, input int vprob, input int cnt);
        int idx;
        int budget;
        idx    = 0;
        budget = 4000;
        while (idx < cnt && budget > 0) begin
            valid_i = ($urandom_range(99) < vprob);
            data_i  = fr_buf[idx];
            mode_i  = (idx == 0) ? m : 1'($urandom);
            @(negedge clk);
            if (valid_i && ready_o) idx++;
            tick();
            budget--;
        end
        valid_i = 1'b0;
        if (budget == 0) check("send_timeout", idx, cnt);
    endtask

    task automatic drain();
        int budget;
        budget = 4000;
        while ((exp_q.size() > 0 || valid_o) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic fill_seq(input int base);
        for (int i = 0; i < N; i++) fr_buf[i] = DW'(base + i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        wcount     = 0;
        fc         = 0;
        lat_cnt    = 0;
        nb_pend    = 0;
        stall_prev = 0;
        #1;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_last", last_o, 0);
        check("rst_data", data_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int c0;
        int budget;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        mode_i  = 1'b0;
        ready_i = 1'b1;
        rpol    = 0;
        n_chk   = 0;
        n_fail  = 0;
        nb_seen = 0;
        consumed = 0;
        do_reset();

        // mode 0, back-to-back, latency and known sequence
        out_log.delete();
        fill_seq(0);
        send_words(1'b0, 100, N);
        check("lat_e0", valid_o, 0);
        @(posedge clk);
        #1;
        check("lat_e1", valid_o, 1);
        check("lat_d0", data_o, 0);
        drain();
        check("m0_len", out_log.size(), N);
        for (int k = 0; k < N && k < out_log.size(); k++)
            check("m0_seq", out_log[k], (k % 4) * 8 + k / 4);

        // mode 1, then loop the result back through mode 0
        out_log.delete();
        send_words(1'b1, 100, N);
        drain();
        check("m1_len", out_log.size(), N);
        for (int k = 0; k < N && k < out_log.size(); k++) begin
            check("m1_seq", out_log[k], (k % 8) * 4 + k / 8);
            fr_buf[k] = out_log[k];
        end
        out_log.delete();
        send_words(1'b0, 100, N);
        drain();
        for (int k = 0; k < N && k < out_log.size(); k++)
            check("loop_seq", out_log[k], k);

        // backpressure: two frames fill both banks, third stalls
        c0   = consumed;
        rpol = 1;
        fill_seq(100);
        send_words(1'b0, 100, N);
        fill_seq(200);
        send_words(1'b1, 100, N);
        fill_seq(300);
        valid_i = 1'b1;
        data_i  = fr_buf[0];
        mode_i  = 1'b0;
        @(negedge clk);
        check("bp_full", ready_o, 0);
        @(posedge clk);
        #1;
        rpol    = 0;
        ready_i = 1'b1;
        n       = 0;
        budget  = 200;
        while (budget > 0) begin
            @(negedge clk);
            if (valid_o && ready_i) n++;
            if (n == N) break;
            @(posedge clk);
            #1;
            budget--;
        end
        check("bp_hold", ready_o, 0);
        @(posedge clk);
        #1;
        check("bp_release", ready_o, 1);
        send_words(1'b0, 100, N);
        drain();
        check("bp_count", consumed - c0, 3 * N);

        // random handshakes, alternating mode
        rpol = 2;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < N; i++) fr_buf[i] = DW'($urandom);
            send_words(1'(f), 70, N);
        end
        drain();

        // reset mid-write, then mid-drain
        rpol = 0;
        fill_seq(0);
        send_words(1'b0, 100, 20);
        do_reset();
        rpol = 1;
        fill_seq(500);
        send_words(1'b1, 100, N);
        ready_i = 1'b1;
        rpol    = 0;
        n       = 0;
        budget  = 200;
        while (n < 10 && budget > 0) begin
            @(negedge clk);
            if (valid_o && ready_i) n++;
            @(posedge clk);
            #1;
            budget--;
        end
        check("rst_drain10", n, 10);
        do_reset();
        out_log.delete();
        fill_seq(0);
        send_words(1'b0, 100, N);
        drain();
        check("post_rst_len", out_log.size(), N);
        for (int k = 0; k < N && k < out_log.size(); k++)
            check("post_rst_seq", out_log[k], (k % 4) * 8 + k / 4);

        // back-to-back frames with continuous handshakes
        n = nb_seen;
        for (int f = 0; f < 3; f++) begin
            fill_seq(1000 * (f + 1));
            send_words(1'(f), 100, N);
        end
        drain();
        check("b2b_seen", nb_seen > n, 1);
        check("final_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/llr_block_interleaver.md
# llr_block_interleaver

Ping-pong row/column block interleaver placed between SISO decoder stages in the turbo decoder loop. It takes 16-bit extrinsic LLR words from one SISO in natural order and delivers them to the next SISO in interleaved order (mode 0) or de-interleaved order (mode 1). Two frame banks let the next frame be written while the previous one is read out.

## Interface
- `ROWS`, 4: interleaver rows.
- `COLS`, 8: interleaver columns. The frame length is N = ROWS*COLS.
- `DW`, 16: LLR word width.
- `clk_p_i` input 1: clock. All logic updates on its rising edge.
- `reset_n_i` input 1: reset. Asynchronous, active-low.
- `data_i` input DW: LLR word in natural order.
- `valid_i` input 1: `data_i` is valid.
- `ready_o` output 1: block can accept a word. A word is accepted when `valid_i && ready_o`.
- `mode_i` input 1: 0 selects interleave, 1 selects de-interleave. Sampled with the first word of each frame.
- `data_o` output DW: permuted LLR word. Registered.
- `valid_o` output 1: `data_o` is valid. Registered.
- `ready_i` input 1: downstream accepts. A word is consumed when `valid_o && ready_i`.
- `last_o` output 1: `data_o` is word N-1 of the frame. Registered.

## Operation
- Storage: two banks, each N x DW. Per bank there is a `full` flag and a stored `mode` bit.
- Write side:
  - `wr_bank` pointer plus a write counter `wcnt` (0..N-1).
  - Words are written to address `wcnt`.
  - The accept that carries `wcnt==0` latches `mode_i` into that bank.
  - The accept that carries `wcnt==N-1` sets `full[wr_bank]`, toggles `wr_bank` and wraps `wcnt` to 0.
- `ready_o` is combinational: `ready_o = !full[wr_bank]`.
- Read side states:
  - IDLE: no full bank at `rd_bank`.
  - DRAIN: emitting the bank.
- Read addressing uses nested counters, with no divider.
  - Mode 0, k-th output: address = (k mod ROWS)*COLS + k div ROWS. The row counter is the inner counter, the column counter the outer.
  - Mode 1, k-th output: address = (k mod COLS)*ROWS + k div COLS.
- IDLE -> DRAIN when `full[rd_bank]` is set. The output register loads element k=0 on that edge.
- In DRAIN, each consume loads the next element into the output register. If `ready_i` is low, `data_o`, `valid_o` and `last_o` hold.
- The consume of the element with `last_o=1`:
  - clears `full[rd_bank]` and toggles `rd_bank`;
  - if the other bank is already full, element 0 of that bank loads on the same edge (no bubble);
  - otherwise `valid_o` drops and the state returns to IDLE.
- Simultaneous events:
  - A write into one bank and a drain of the other bank in the same cycle is normal operation.
  - The same bank is never written and read at once; the `full` flags guarantee this.
- Mode change mid-frame has no effect. Only the `mode_i` value at word 0 of a frame matters.
- Reset, including mid-frame: both `full` flags clear, both pointers go to bank 0, all counters go to 0, and the state goes to IDLE. Partially written and partially drained frames are discarded.
- Values after reset: `ready_o`=1, `valid_o`=0, `last_o`=0, `data_o`=0.

## Timing
- Latency: if the last input word is accepted at edge E, then `valid_o`=1 with element 0 from edge E+1.
- Throughput: one word per cycle on each side in steady state.
  - Continuous `valid_i` and `ready_i` sustain N words in and N words out every N cycles.
  - The input never stalls once the first frame is draining.
- Backpressure on the write side:
  - With both banks full, `ready_o`=0.
  - `ready_o` returns to 1 in the cycle after the edge on which the last word of a bank is consumed.
- `last_o` is high exactly with output element N-1.

## Test plan
- Reset, then `mode_i`=0, feed `data_i`=0..31 back-to-back, `ready_i`=1.
  - Required output: 0,8,16,24,1,9,17,25,…,7,15,23,31.
  - `valid_o` rises the edge after word 31 is accepted.
  - `last_o` is high only with 31.
- `mode_i`=1, feed 0..31.
  - Required output: 0,4,8,…,28,1,5,…,29,…,3,7,…,31.
  - Loop that output back through the block in mode 0; it must reproduce 0..31.
- Hold `ready_i`=0 and stream three frames.
  - 64 words are accepted; `ready_o`=0 at the 65th word.
  - Raise `ready_i`: 32 outputs drain; `ready_o`=1 the cycle after the 32nd output is consumed.
  - No data is lost or duplicated across all 96 words.
- Randomly toggle `ready_i` and `valid_i` over 10 frames of alternating mode.
  - The output sequence must match the reference permutation per frame.
  - `data_o` must be stable whenever `valid_o && !ready_i`.
- Assert reset after 20 words of a frame and after 10 outputs of another frame.
  - All outputs return to their reset values immediately.
  - A fresh frame 0..31 afterwards produces the exact mode-0 sequence.
- Back-to-back frames with continuous `valid_i`/`ready_i`: there is no idle cycle between output element 31 of frame n and element 0 of frame n+1.
